rmii_frame_tx: RTL and testbench

RMII_FRAME_TX -- requirements
Module: rmii_frame_tx

---
 rtl/rmii_frame_tx_pkg.sv | 46 ++++
 rtl/rmii_frame_tx_crc32_dibit.sv | 26 ++
 rtl/rmii_frame_tx.sv | 130 +++++++++++++
 tb/tb_rmii_frame_tx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rmii_frame_tx_pkg.sv
// Shared types and constants for the RMII Ethernet frame transmitter.
// The FCS state exists only when RMII_FRAME_TX_FCS_EN is defined.
package rmii_frame_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_HEADER   = 3'd2,
        ST_PAYLOAD  = 3'd3,
        ST_PAD      = 3'd4,
`ifdef RMII_FRAME_TX_FCS_EN
        ST_FCS      = 3'd5,
`endif
        ST_IFG      = 3'd6
    } tx_state_e;

    localparam logic [7:0] PREAMBLE_BYTE  = 8'h55;
    localparam logic [7:0] SFD_BYTE       = 8'hD5;
    localparam int         PREAMBLE_BYTES = 8;
    localparam int         HEADER_BYTES   = 14;
    localparam int         MIN_DATA_BYTES = 46;
    localparam int         FCS_BYTES      = 4;
    localparam int         IFG_CYCLES     = 48;

    function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC_POLY_REFL = bit_reverse32(CRC_POLY);

    // Reflected CRC-32 update for one dibit; bit 0 is the first bit on the wire.
    function automatic logic [31:0] crc32_step_dibit(input logic [31:0] crc,
                                                     input logic [1:0]  dibit);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 2; i++) begin
            c = (c[0] ^ dibit[i]) ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/rmii_frame_tx_crc32_dibit.sv
// Reflected CRC-32 accumulator consuming one RMII dibit per clock.
// Instantiated by rmii_frame_tx only when RMII_FRAME_TX_FCS_EN is defined.
module crc32_dibit
    import rmii_frame_tx_pkg::*;
(
    input  logic        clk,
    input  logic        i_clear,
    input  logic        i_en,
    input  logic [1:0]  i_dibit,
    output logic [31:0] o_crc
);

    logic [31:0] r_crc;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_crc <= 32'hFFFF_FFFF;
        end else if (i_en) begin
            r_crc <= crc32_step_dibit(r_crc, i_dibit);
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/rmii_frame_tx.sv
// RMII (2-bit, 50 MHz) transmitter for one fixed-header Ethernet frame per start pulse.
// Define RMII_FRAME_TX_FCS_EN to append the CRC-32 frame check sequence.
module rmii_frame_tx
    import rmii_frame_tx_pkg::*;
#(
    parameter logic [47:0] SRC_MAC              = 48'h0,
    parameter logic [47:0] DST_MAC              = 48'h0,
    parameter logic [15:0] ETHERTYPE            = 16'h0,
    parameter int          PAYLOAD_LENGTH_BYTES = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [8*PAYLOAD_LENGTH_BYTES-1:0] payload,
    input  logic                              start,
    output logic                              busy,
    output logic                              txen,
    output logic [1:0]                        txd
);

    localparam int             PW            = 8 * PAYLOAD_LENGTH_BYTES;
    localparam logic [111:0]   HEADER        = {DST_MAC, SRC_MAC, ETHERTYPE};
    localparam bit             HAS_PAD       = PAYLOAD_LENGTH_BYTES < MIN_DATA_BYTES;
    localparam logic [7:0]     LAST_PREAMBLE = 8'(4 * PREAMBLE_BYTES - 1);
    localparam logic [7:0]     LAST_HEADER   = 8'(4 * HEADER_BYTES - 1);
    localparam logic [7:0]     LAST_PAYLOAD  = 8'(4 * PAYLOAD_LENGTH_BYTES - 1);
    localparam logic [7:0]     LAST_PAD      = 8'(4 * (MIN_DATA_BYTES - PAYLOAD_LENGTH_BYTES) - 1);
    localparam logic [7:0]     LAST_IFG      = 8'(IFG_CYCLES - 1);
`ifdef RMII_FRAME_TX_FCS_EN
    localparam logic [7:0]     LAST_FCS      = 8'(4 * FCS_BYTES - 1);
    localparam tx_state_e      AFTER_DATA    = ST_FCS;
`else
    localparam tx_state_e      AFTER_DATA    = ST_IFG;
`endif

    tx_state_e   r_state, w_state_next;
    logic [7:0]  r_cnt, w_cnt_next;
    logic [PW-1:0] r_payload;
    logic [5:0]  w_byte_idx;
    logic [7:0]  w_byte;
    logic [1:0]  w_dibit;

    assign w_byte_idx = r_cnt[7:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // NOTE: the payload holding register is pure datapath and is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!rst && r_state == ST_IDLE && start) begin
            r_payload <= payload;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 8'd1;
        case (r_state)
            ST_IDLE:     if (start) w_state_next = ST_PREAMBLE;
            ST_PREAMBLE: if (r_cnt == LAST_PREAMBLE) w_state_next = ST_HEADER;
            ST_HEADER:   if (r_cnt == LAST_HEADER) w_state_next = ST_PAYLOAD;
            ST_PAYLOAD:  if (r_cnt == LAST_PAYLOAD) w_state_next = HAS_PAD ? ST_PAD : AFTER_DATA;
            ST_PAD:      if (r_cnt == LAST_PAD) w_state_next = AFTER_DATA;
`ifdef RMII_FRAME_TX_FCS_EN
            ST_FCS:      if (r_cnt == LAST_FCS) w_state_next = ST_IFG;
`endif
            ST_IFG:      if (r_cnt == LAST_IFG) w_state_next = ST_IDLE;
            default:     w_state_next = ST_IDLE;
        endcase
        // The per-state dibit counter restarts on every state change and stays cleared while idle.
        if (w_state_next != r_state || r_state == ST_IDLE) w_cnt_next = '0;
    end

`ifdef RMII_FRAME_TX_FCS_EN
    logic [31:0] w_crc;
    logic [31:0] w_fcs;
    logic        w_crc_en;

    assign w_crc_en = (r_state == ST_HEADER) || (r_state == ST_PAYLOAD) || (r_state == ST_PAD);
    assign w_fcs    = ~w_crc;

    crc32_dibit u_crc (
        .clk     (clk),
        .i_clear (rst || r_state == ST_IDLE),
        .i_en    (w_crc_en),
        .i_dibit (w_dibit),
        .o_crc   (w_crc)
    );
`endif

    // Byte under transmission, then the dibit within it (bits [1:0] first).
    always_comb begin
        txen   = 1'b0;
        w_byte = 8'h00;
        case (r_state)
            ST_PREAMBLE: begin
                txen   = 1'b1;
                w_byte = (w_byte_idx == 6'd7) ? SFD_BYTE : PREAMBLE_BYTE;
            end
            ST_HEADER: begin
                txen   = 1'b1;
                w_byte = HEADER[8 * (HEADER_BYTES - 1 - int'(w_byte_idx)) +: 8];
            end
            ST_PAYLOAD: begin
                txen   = 1'b1;
                w_byte = r_payload[8 * (PAYLOAD_LENGTH_BYTES - 1 - int'(w_byte_idx)) +: 8];
            end
            ST_PAD: txen = 1'b1;
`ifdef RMII_FRAME_TX_FCS_EN
            ST_FCS: begin
                txen   = 1'b1;
                w_byte = w_fcs[8 * int'(w_byte_idx) +: 8];
            end
`endif
            default: ;
        endcase
        w_dibit = w_byte[{r_cnt[1:0], 1'b0} +: 2];
    end

    assign txd  = txen ? w_dibit : 2'b00;
    assign busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_rmii_frame_tx.sv
// Randomized self-checking bench for rmii_frame_tx: a 2-byte and a 46-byte payload instance
// compared against a byte-level Ethernet frame model with an independent MSB-first CRC-32.
module tb_rmii_frame_tx;

    localparam logic [47:0] SRC = 48'h02_11_22_33_44_55;
    localparam logic [47:0] DST = 48'h00_1A_2B_3C_4D_5E;
    localparam logic [15:0] ETH = 16'h88B5;
`ifdef RMII_FRAME_TX_FCS_EN
    localparam int FRAME_CYC = 288;
`else
    localparam int FRAME_CYC = 272;
`endif
    localparam int IFG       = 48;
    localparam int BUDGET    = 2000;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_a, start_b;
    logic [15:0]  pay_a;
    logic [367:0] pay_b;
    logic         busy_a, txen_a, busy_b, txen_b;
    logic [1:0]   txd_a, txd_b;

    always #10 clk = ~clk;

    rmii_frame_tx #(.SRC_MAC(SRC), .DST_MAC(DST), .ETHERTYPE(ETH), .PAYLOAD_LENGTH_BYTES(2)) dut_a (
        .clk(clk), .rst(rst), .payload(pay_a), .start(start_a),
        .busy(busy_a), .txen(txen_a), .txd(txd_a));

    rmii_frame_tx #(.SRC_MAC(SRC), .DST_MAC(DST), .ETHERTYPE(ETH), .PAYLOAD_LENGTH_BYTES(46)) dut_b (
        .clk(clk), .rst(rst), .payload(pay_b), .start(start_b),
        .busy(busy_b), .txen(txen_b), .txd(txd_b));

    // Observation mux: only the selected instance is ever transmitting.
    logic       sel;
    logic       m_busy, m_txen;
    logic [1:0] m_txd;
    assign m_busy = sel ? busy_b : busy_a;
    assign m_txen = sel ? txen_b : txen_a;
    assign m_txd  = sel ? txd_b  : txd_a;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [1:0] cap[$];
    logic [7:0] exp_bytes[$];
    logic [7:0] got_bytes[$];
    int         rises, bad_idle, busy_cnt, gap_cnt;
    logic       prev_txen = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_txen) cap.push_back(m_txd);
        if (m_txen && !prev_txen) rises++;
        if (!m_txen && m_txd != 2'b00) bad_idle++;
        if (m_busy) busy_cnt++;
        if (m_busy && !m_txen) gap_cnt++;
        prev_txen = m_txen;
    end

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // Textbook MSB-first CRC-32 shift register fed with bits in wire order.
    function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic b);
        return {c[30:0], 1'b0} ^ ((c[31] ^ b) ? 32'h04C11DB7 : 32'h0);
    endfunction

    task automatic build_expected(input logic [367:0] pay, input int plen);
        exp_bytes.delete();
        repeat (7) exp_bytes.push_back(8'h55);
        exp_bytes.push_back(8'hD5);
        for (int i = 0; i < 6; i++) exp_bytes.push_back(DST[8*(5-i) +: 8]);
        for (int i = 0; i < 6; i++) exp_bytes.push_back(SRC[8*(5-i) +: 8]);
        exp_bytes.push_back(ETH[15:8]);
        exp_bytes.push_back(ETH[7:0]);
        for (int i = 0; i < plen; i++) exp_bytes.push_back(pay[8*(plen-1-i) +: 8]);
        for (int i = plen; i < 46; i++) exp_bytes.push_back(8'h00);
`ifdef RMII_FRAME_TX_FCS_EN
        begin
            logic [31:0] c, fcs;
            c = 32'hFFFF_FFFF;
            for (int k = 8; k < exp_bytes.size(); k++)
                for (int b = 0; b < 8; b++) c = crc_bit(c, exp_bytes[k][b]);
            fcs = ~rev32(c);
            for (int i = 0; i < 4; i++) exp_bytes.push_back(fcs[8*i +: 8]);
        end
`endif
    endtask

    task automatic verify_frame(input logic [367:0] pay, input int plen);
        int n_mis, n_pad;
        build_expected(pay, plen);
        got_bytes.delete();
        for (int k = 0; k < cap.size() / 4; k++)
            got_bytes.push_back({cap[4*k+3], cap[4*k+2], cap[4*k+1], cap[4*k]});
        check("txen_cycles", cap.size(), FRAME_CYC);
        n_mis = 0;
        for (int i = 0; i < exp_bytes.size(); i++)
            if (i >= got_bytes.size() || got_bytes[i] !== exp_bytes[i]) n_mis++;
        check("byte_mismatches", n_mis, 0);
        check("preamble_sfd", {got_bytes[0], got_bytes[1], got_bytes[2], got_bytes[3],
                               got_bytes[4], got_bytes[5], got_bytes[6], got_bytes[7]},
              64'h5555_5555_5555_55D5);
        check("payload_first", got_bytes[22], pay[8*(plen-1) +: 8]);
        check("payload_last", got_bytes[21+plen], pay[7:0]);
        n_pad = 0;
        for (int i = 22 + plen; i < 68; i++) if (got_bytes[i] !== 8'h00) n_pad++;
        check("pad_nonzero", n_pad, 0);
        check("txen_pulses", rises, 1);
        check("txd_idle_zero", bad_idle, 0);
        check("ifg_cycles", gap_cnt, IFG);
        check("busy_cycles", busy_cnt, FRAME_CYC + IFG);
`ifdef RMII_FRAME_TX_FCS_EN
        begin
            logic [31:0] c;
            c = 32'hFFFF_FFFF;
            for (int k = 8; k < got_bytes.size(); k++)
                for (int b = 0; b < 8; b++) c = crc_bit(c, got_bytes[k][b]);
            check("crc_residue", rev32(c), 32'hDEBB20E3);
        end
`endif
    endtask

    task automatic clear_monitor();
        cap.delete();
        rises = 0; bad_idle = 0; busy_cnt = 0; gap_cnt = 0;
    endtask

    task automatic scramble_payloads();
        pay_a = 16'($urandom);
        for (int i = 0; i < 46; i++) pay_b[8*i +: 8] = 8'($urandom);
    endtask

    // Called #1 after a rising edge with the selected instance idle; returns likewise with busy low.
    task automatic run_frame(input bit which, input logic [367:0] pay, input bit extra_starts);
        int c, plen;
        plen = which ? 46 : 2;
        sel  = which;
        clear_monitor();
        if (which) begin pay_b = pay; start_b = 1'b1; end
        else       begin pay_a = pay[15:0]; start_a = 1'b1; end
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        check("txen_after_start", m_txen, 1);
        check("busy_after_start", m_busy, 1);
        c = 0;
        do begin
            @(posedge clk); #1;
            c++;
            if (c == 1) scramble_payloads();
            if (extra_starts) begin
                if (which) start_b = (c == 5 || c == 200 || c == 300);
                else       start_a = (c == 5 || c == 200 || c == 300);
            end
        end while (m_busy && c < BUDGET);
        start_a = 1'b0; start_b = 1'b0;
        check("busy_falls_in_budget", (c < BUDGET), 1);
        verify_frame(pay, plen);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [367:0] p;
        rst = 1'b1; sel = 1'b0;
        start_a = 1'b1; start_b = 1'b1;
        pay_a = 16'hAAAA; pay_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy_a", busy_a, 0);
        check("rst_txen_a", txen_a, 0);
        check("rst_txd_a", txd_a, 0);
        check("rst_busy_b", busy_b, 0);
        check("rst_txen_b", txen_b, 0);
        rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("start_with_rst_ignored_a", busy_a, 0);
        check("start_with_rst_ignored_b", busy_b, 0);

        run_frame(1'b0, {352'h0, 16'hBEEF}, 1'b0);
        run_frame(1'b0, {352'h0, 16'($urandom)}, 1'b1);
        run_frame(1'b0, {352'h0, 16'($urandom)}, 1'b0);

        // Abort mid-frame, then restart on the first cycle after reset drops.
        sel = 1'b0;
        clear_monitor();
        pay_a = 16'h1234; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_txen", txen_a, 0);
        check("abort_txd", txd_a, 0);
        check("abort_busy", busy_a, 0);
        rst = 1'b0;
        run_frame(1'b0, {352'h0, 16'($urandom)}, 1'b0);

        for (int i = 0; i < 46; i++) p[8*(45-i) +: 8] = 8'(i);
        run_frame(1'b1, p, 1'b0);
        for (int i = 0; i < 46; i++) p[8*i +: 8] = 8'($urandom);
        run_frame(1'b1, p, 1'b0);
        run_frame(1'b0, {352'h0, 16'($urandom)}, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
